// File: rtl/mem_pattern_checker.sv
// Memory self-test engine: writes a pattern over an address window, reads it back, reports errors.
// States: IDLE idle after reset | WRITE write pass | READ issue read | WAIT_RSP await read data | CHECK_END pass bookkeeping | DONE finished
module mem_pattern_checker #(
  parameter int          ADDR_W    = 16,
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 1024,
  parameter int          BASE_ADDR = 0,
  parameter int          ERR_CNT_W = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2024
) (
  input  logic                 io_systemClk,
  input  logic                 io_systemReset,
  input  logic                 io_start,
  input  logic [1:0]           io_mode,
  input  logic                 io_continuous,
  output logic                 mem_cmd_valid,
  input  logic                 mem_cmd_ready,
  output logic                 mem_cmd_write,
  output logic [ADDR_W-1:0]    mem_cmd_addr,
  output logic [DATA_W-1:0]    mem_cmd_wdata,
  input  logic                 mem_rsp_valid,
  input  logic [DATA_W-1:0]    mem_rsp_rdata,
  output logic                 busy,
  output logic                 memoryCheckerPass,
  output logic                 memoryCheckerFail,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic [15:0]          pass_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_READ, ST_WAIT_RSP, ST_CHECK_END, ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [31:0]          lfsr_q, lfsr_d;
  logic [1:0]           mode_q, mode_d;
  logic                 cont_q, cont_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]    first_err_q, first_err_d;
  logic                 fail_q, fail_d;
  logic                 pass_q, pass_d;
  logic                 pass_err_q, pass_err_d;
  logic [15:0]          pass_cnt_q, pass_cnt_d;

  logic [ADDR_W-1:0] addr_cur;
  logic [31:0]       lfsr_nxt;
  logic [31:0]       bit_pos;
  logic [DATA_W-1:0] pat;
  logic              last;

  assign addr_cur = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
  // x^32 + x^22 + x^2 + x + 1, shifting left with feedback into bit 0
  assign lfsr_nxt = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  assign bit_pos  = 32'(idx_q) % 32'(DATA_W);
  assign last     = (idx_q == IDX_LAST);

  always_comb begin
    pat = '0;
    case (mode_q)
      2'd0: pat = DATA_W'(addr_cur);
      2'd1: pat = DATA_W'({lfsr_q, lfsr_q});
      2'd2: pat = DATA_W'(1) << bit_pos;
      2'd3: pat = ~DATA_W'(addr_cur);
      default: pat = '0;
    endcase
  end

  assign mem_cmd_valid     = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign mem_cmd_write     = (state_q == ST_WRITE);
  assign mem_cmd_addr      = mem_cmd_valid ? addr_cur : '0;
  assign mem_cmd_wdata     = mem_cmd_write ? pat : '0;
  assign busy              = (state_q == ST_WRITE) || (state_q == ST_READ) ||
                             (state_q == ST_WAIT_RSP) || (state_q == ST_CHECK_END);
  assign memoryCheckerPass = pass_q;
  assign memoryCheckerFail = fail_q;
  assign err_count         = err_cnt_q;
  assign first_err_addr    = first_err_q;
  assign pass_count        = pass_cnt_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lfsr_d      = lfsr_q;
    mode_d      = mode_q;
    cont_d      = cont_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    fail_d      = fail_q;
    pass_d      = pass_q;
    pass_err_d  = pass_err_q;
    pass_cnt_d  = pass_cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (io_start) begin
          mode_d      = io_mode;
          cont_d      = io_continuous;
          idx_d       = '0;
          lfsr_d      = LFSR_SEED;
          err_cnt_d   = '0;
          first_err_d = '0;
          fail_d      = 1'b0;
          pass_d      = 1'b0;
          pass_err_d  = 1'b0;
          pass_cnt_d  = '0;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_cmd_ready) begin
          if (last) begin
            idx_d   = '0;
            lfsr_d  = LFSR_SEED;
            state_d = ST_READ;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            lfsr_d = lfsr_nxt;
          end
        end
      end
      ST_READ: begin
        if (mem_cmd_ready) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_rdata != pat) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            // fail_q is sticky since start, so it marks whether an error was already seen
            if (!fail_q) first_err_d = addr_cur;
            fail_d     = 1'b1;
            pass_err_d = 1'b1;
          end
          if (last) begin
            idx_d   = '0;
            lfsr_d  = LFSR_SEED;
            state_d = ST_CHECK_END;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            lfsr_d  = lfsr_nxt;
            state_d = ST_READ;
          end
        end
      end
      ST_CHECK_END: begin
        pass_cnt_d = pass_cnt_q + 16'(1);
        pass_d     = !pass_err_q;
        if (cont_q) begin
          pass_err_d = 1'b0;
          state_d    = ST_WRITE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      mode_q      <= '0;
      cont_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      fail_q      <= 1'b0;
      pass_q      <= 1'b0;
      pass_err_q  <= 1'b0;
      pass_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lfsr_q      <= lfsr_d;
      mode_q      <= mode_d;
      cont_q      <= cont_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      fail_q      <= fail_d;
      pass_q      <= pass_d;
      pass_err_q  <= pass_err_d;
      pass_cnt_q  <= pass_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_pattern_checker.sv
// Bench for mem_pattern_checker: behavioural memory responder plus pattern/error reference model.
module tb_mem_pattern_checker;
  localparam int          ADDR_W = 16;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 64;
  localparam int          BASE   = 16'h0010;
  localparam int          ECW    = 4;
  localparam logic [31:0] SEED   = 32'hACE1_2024;

  logic              clk = 1'b0;
  logic              io_systemReset;
  logic              io_start;
  logic [1:0]        io_mode;
  logic              io_continuous;
  logic              mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [DATA_W-1:0] mem_cmd_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;
  logic              busy, pass_o, fail_o;
  logic [ECW-1:0]    err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [15:0]       pass_count;

  mem_pattern_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE),
                        .ERR_CNT_W(ECW), .LFSR_SEED(SEED)) dut (
    .io_systemClk(clk), .io_systemReset(io_systemReset), .io_start(io_start),
    .io_mode(io_mode), .io_continuous(io_continuous),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_write(mem_cmd_write),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .busy(busy), .memoryCheckerPass(pass_o), .memoryCheckerFail(fail_o),
    .err_count(err_count), .first_err_addr(first_err_addr), .pass_count(pass_count));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // memory responder knobs and logs
  logic [31:0] mem [0:65535];
  bit          rand_ready = 0;
  int          max_extra  = 0;
  bit          zero_reads = 0;
  bit          corrupt_en = 0;
  logic [15:0] corrupt_addr = '0;
  logic [15:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [15:0] rd_addr_q[$];
  int          stall_checks = 0;
  int          stall_viol   = 0;
  logic [31:0] lfsr_seq [DEPTH];

  initial begin
    bit          pending, prev_valid, prev_ready, prev_write;
    int          rsp_wait;
    logic [31:0] pend_data, prev_wdata;
    logic [15:0] prev_addr;
    pending = 0; prev_valid = 0; prev_ready = 0; prev_write = 0; rsp_wait = 0;
    pend_data = 0; prev_wdata = 0; prev_addr = 0;
    mem_cmd_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
    forever begin
      @(negedge clk); #1;
      mem_rsp_valid = 0;
      if (io_systemReset) begin
        pending = 0; prev_valid = 0;
      end else begin
        if (prev_valid && !prev_ready) begin
          stall_checks++;
          if (!mem_cmd_valid || mem_cmd_write !== prev_write || mem_cmd_addr !== prev_addr ||
              mem_cmd_wdata !== prev_wdata) stall_viol++;
        end
        if (pending) begin
          if (rsp_wait == 0) begin
            mem_rsp_valid = 1; mem_rsp_rdata = pend_data; pending = 0;
          end else rsp_wait--;
        end
        mem_cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mem_cmd_valid && mem_cmd_ready) begin
          if (mem_cmd_write) begin
            mem[mem_cmd_addr] = mem_cmd_wdata;
            wr_addr_q.push_back(mem_cmd_addr);
            wr_data_q.push_back(mem_cmd_wdata);
          end else begin
            rd_addr_q.push_back(mem_cmd_addr);
            pend_data = zero_reads ? 32'h0 :
                        mem[mem_cmd_addr] ^ ((corrupt_en && mem_cmd_addr == corrupt_addr) ? 32'h1 : 32'h0);
            pending  = 1;
            rsp_wait = $urandom_range(0, max_extra);
          end
        end
        prev_valid = mem_cmd_valid; prev_ready = mem_cmd_ready; prev_write = mem_cmd_write;
        prev_addr = mem_cmd_addr; prev_wdata = mem_cmd_wdata;
      end
    end
  end

  function automatic logic [31:0] exp_pat(int mode, int idx);
    logic [15:0] a;
    a = 16'(BASE + idx);
    case (mode)
      0: return {16'h0, a};
      1: return lfsr_seq[idx];
      2: return 32'h1 << (idx % DATA_W);
      default: return ~{16'h0, a};
    endcase
  endfunction

  // value the responder will hand back for word idx under the current fault knobs
  function automatic logic [31:0] exp_read(int mode, int idx);
    if (zero_reads) return 32'h0;
    return exp_pat(mode, idx) ^ ((corrupt_en && 16'(BASE + idx) == corrupt_addr) ? 32'h1 : 32'h0);
  endfunction

  function automatic int exp_err_sat(int mode);
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (exp_read(mode, i) != exp_pat(mode, i)) n++;
    return (n > (1 << ECW) - 1) ? (1 << ECW) - 1 : n;
  endfunction

  function automatic logic [15:0] exp_first_err(int mode);
    for (int i = 0; i < DEPTH; i++) if (exp_read(mode, i) != exp_pat(mode, i)) return 16'(BASE + i);
    return 16'h0;
  endfunction

  function automatic int write_mismatches(int mode);
    int bad = 0;
    if (wr_addr_q.size() != DEPTH) return DEPTH + 1;
    for (int i = 0; i < DEPTH; i++)
      if (wr_addr_q[i] !== 16'(BASE + i) || wr_data_q[i] !== exp_pat(mode, i)) bad++;
    return bad;
  endfunction

  function automatic int read_order_mismatches();
    int bad = 0;
    if (rd_addr_q.size() != DEPTH) return DEPTH + 1;
    for (int i = 0; i < DEPTH; i++) if (rd_addr_q[i] !== 16'(BASE + i)) bad++;
    return bad;
  endfunction

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
  endtask

  task automatic do_start(int mode, bit cont);
    @(negedge clk);
    io_mode = 2'(mode); io_continuous = cont; io_start = 1;
    @(negedge clk);
    io_start = 0;
  endtask

  task automatic wait_done(output int cycles, output bit ok);
    cycles = 0;
    while (busy && cycles < 20000) begin cycles++; @(negedge clk); end
    ok = !busy;
  endtask

  task automatic test_reset();
    io_systemReset = 1;
    repeat (3) @(negedge clk);
    io_systemReset = 0;
    @(negedge clk);
    n_checks++;
    if ({mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata, busy, pass_o, fail_o,
         err_count, first_err_addr, pass_count} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got valid=%0b busy=%0b pass=%0b fail=%0b err=%0d pc=%0d expected all 0",
                         mem_cmd_valid, busy, pass_o, fail_o, err_count, pass_count);
    end
  endtask

  task automatic test_zero_wait();
    int cyc; bit ok; int wm, rm;
    rand_ready = 0; max_extra = 0; zero_reads = 0; corrupt_en = 0;
    clear_logs();
    do_start(0, 0);
    wait_done(cyc, ok);
    wm = write_mismatches(0); rm = read_order_mismatches();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zw_timeout: got busy=1 expected done"); end
    n_checks++; if (cyc != 3 * DEPTH + 1) begin n_fail++; $display("FAIL zw_latency: got %0d expected %0d", cyc, 3 * DEPTH + 1); end
    n_checks++; if (wm != 0) begin n_fail++; $display("FAIL zw_writes: got %0d bad writes expected 0", wm); end
    n_checks++; if (rm != 0) begin n_fail++; $display("FAIL zw_reads: got %0d bad reads expected 0", rm); end
    n_checks++;
    if (pass_count !== 16'd1 || pass_o !== 1'b1 || fail_o !== 1'b0 || err_count !== '0) begin
      n_fail++; $display("FAIL zw_status: got pc=%0d pass=%0b fail=%0b err=%0d expected 1 1 0 0",
                         pass_count, pass_o, fail_o, err_count);
    end
  endtask

  task automatic test_corrupt();
    int cyc; bit ok; logic [ECW-1:0] e_err; logic [15:0] e_first;
    rand_ready = 0; max_extra = 0; zero_reads = 0; corrupt_en = 1; corrupt_addr = 16'h0013;
    e_err = ECW'(exp_err_sat(2)); e_first = exp_first_err(2);
    clear_logs();
    do_start(2, 0);
    wait_done(cyc, ok);
    corrupt_en = 0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL cor_timeout: got busy=1 expected done"); end
    n_checks++; if (write_mismatches(2) != 0) begin n_fail++; $display("FAIL cor_writes: got %0d bad writes expected 0", write_mismatches(2)); end
    n_checks++; if (err_count !== e_err) begin n_fail++; $display("FAIL cor_err_count: got %0d expected %0d", err_count, e_err); end
    n_checks++; if (first_err_addr !== e_first) begin n_fail++; $display("FAIL cor_first_addr: got %0h expected %0h", first_err_addr, e_first); end
    n_checks++;
    if (fail_o !== 1'b1 || pass_o !== 1'b0 || pass_count !== 16'd1) begin
      n_fail++; $display("FAIL cor_flags: got fail=%0b pass=%0b pc=%0d expected 1 0 1", fail_o, pass_o, pass_count);
    end
  endtask

  task automatic test_random_stall();
    int cyc; bit ok; int wm, rm;
    rand_ready = 1; max_extra = 5; zero_reads = 0; corrupt_en = 0;
    stall_checks = 0; stall_viol = 0;
    clear_logs();
    do_start(1, 0);
    repeat (60) @(negedge clk);
    io_mode = 2'd0; io_start = 1;
    @(negedge clk);
    io_start = 0;
    wait_done(cyc, ok);
    wm = write_mismatches(1); rm = read_order_mismatches();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rs_timeout: got busy=1 expected done"); end
    n_checks++; if (wm != 0) begin n_fail++; $display("FAIL rs_lfsr_writes: got %0d bad writes expected 0", wm); end
    n_checks++; if (rm != 0) begin n_fail++; $display("FAIL rs_read_order: got %0d bad reads expected 0", rm); end
    n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL rs_stall_stable: got %0d unstable of %0d expected 0", stall_viol, stall_checks); end
    n_checks++; if (stall_checks == 0) begin n_fail++; $display("FAIL rs_stall_seen: got 0 stalled cycles expected >0"); end
    n_checks++;
    if (pass_o !== 1'b1 || fail_o !== 1'b0 || err_count !== '0 || pass_count !== 16'd1) begin
      n_fail++; $display("FAIL rs_status: got pass=%0b fail=%0b err=%0d pc=%0d expected 1 0 0 1",
                         pass_o, fail_o, err_count, pass_count);
    end
    rand_ready = 0; max_extra = 0;
  endtask

  task automatic test_continuous();
    int budget;
    rand_ready = 0; max_extra = 0; zero_reads = 0; corrupt_en = 0; corrupt_addr = 16'(BASE + 5);
    do_start(0, 1);
    for (int p = 1; p <= 5; p++) begin
      budget = 0;
      while (pass_count != 16'(p) && budget < 2000) begin budget++; @(negedge clk); end
      n_checks++;
      if (pass_count !== 16'(p) || pass_o !== (p != 4) || fail_o !== (p >= 4) || busy !== 1'b1) begin
        n_fail++; $display("FAIL cont_pass%0d: got pc=%0d pass=%0b fail=%0b busy=%0b expected %0d %0b %0b 1",
                           p, pass_count, pass_o, fail_o, busy, p, p != 4, p >= 4);
      end
      corrupt_en = (p == 3);
    end
    n_checks++;
    if (err_count !== ECW'(1) || first_err_addr !== 16'(BASE + 5)) begin
      n_fail++; $display("FAIL cont_err: got err=%0d first=%0h expected 1 %0h", err_count, first_err_addr, BASE + 5);
    end
    io_systemReset = 1;
    @(negedge clk);
    io_systemReset = 0;
    n_checks++;
    if ({busy, pass_count, fail_o, err_count} !== '0) begin
      n_fail++; $display("FAIL cont_reset: got busy=%0b pc=%0d fail=%0b err=%0d expected 0", busy, pass_count, fail_o, err_count);
    end
  endtask

  task automatic test_reset_mid();
    int budget, cyc; bit ok;
    rand_ready = 1; max_extra = 2; zero_reads = 0; corrupt_en = 0;
    do_start(0, 0);
    budget = 0;
    while (!(mem_cmd_valid && !mem_cmd_write && mem_cmd_addr == 16'(BASE + 20)) && budget < 2000) begin
      budget++; @(negedge clk);
    end
    n_checks++; if (budget >= 2000) begin n_fail++; $display("FAIL rm_reach_read20: got timeout expected read of %0h", BASE + 20); end
    io_systemReset = 1;
    @(negedge clk);
    io_systemReset = 0;
    n_checks++;
    if ({mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata, busy, pass_o, fail_o,
         err_count, first_err_addr, pass_count} !== '0) begin
      n_fail++; $display("FAIL rm_outputs: got valid=%0b addr=%0h busy=%0b expected all 0", mem_cmd_valid, mem_cmd_addr, busy);
    end
    rand_ready = 0; max_extra = 0;
    repeat (2) @(negedge clk);
    clear_logs();
    do_start(0, 0);
    wait_done(cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rm_timeout: got busy=1 expected done"); end
    n_checks++; if (write_mismatches(0) != 0) begin n_fail++; $display("FAIL rm_rerun_writes: got %0d bad writes expected 0", write_mismatches(0)); end
    n_checks++;
    if (pass_o !== 1'b1 || pass_count !== 16'd1 || fail_o !== 1'b0) begin
      n_fail++; $display("FAIL rm_rerun_status: got pass=%0b pc=%0d fail=%0b expected 1 1 0", pass_o, pass_count, fail_o);
    end
  endtask

  task automatic test_saturate();
    int cyc; bit ok; logic [ECW-1:0] e_err; logic [15:0] e_first;
    rand_ready = 0; max_extra = 0; zero_reads = 1; corrupt_en = 0;
    e_err = ECW'(exp_err_sat(3)); e_first = exp_first_err(3);
    clear_logs();
    do_start(3, 0);
    wait_done(cyc, ok);
    zero_reads = 0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_timeout: got busy=1 expected done"); end
    n_checks++; if (write_mismatches(3) != 0) begin n_fail++; $display("FAIL sat_writes: got %0d bad writes expected 0", write_mismatches(3)); end
    n_checks++; if (err_count !== e_err) begin n_fail++; $display("FAIL sat_err_count: got %0d expected %0d", err_count, e_err); end
    n_checks++; if (first_err_addr !== e_first) begin n_fail++; $display("FAIL sat_first_addr: got %0h expected %0h", first_err_addr, e_first); end
    n_checks++;
    if (fail_o !== 1'b1 || pass_o !== 1'b0) begin
      n_fail++; $display("FAIL sat_flags: got fail=%0b pass=%0b expected 1 0", fail_o, pass_o);
    end
  endtask

  initial begin
    logic [31:0] s;
    io_systemReset = 1; io_start = 0; io_mode = 0; io_continuous = 0;
    s = SEED;
    for (int i = 0; i < DEPTH; i++) begin
      lfsr_seq[i] = s;
      s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    end
    test_reset();
    test_zero_wait();
    test_corrupt();
    test_random_stall();
    test_continuous();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_pattern_checker.md
Name: mem_pattern_checker

Overview:
- Parametrised memory self-test engine. Successor to the single-bit memoryCheckerPass logic on the Ti60 SoC top.
- Writes a selectable data pattern across a configurable address window through a simple valid/ready memory port, then reads it back and compares each word.
- Reports pass/fail, error count and the first failing address.
- Sits in the io_systemClk domain beside the SoC. Its pass flag drives the board LED / memoryCheckerPass pin.

Parameters:
ADDR_W, 16, memory word-address width
DATA_W, 32, memory data width (8..64)
DEPTH, 1024, words tested, starting at BASE_ADDR (1..2^ADDR_W)
BASE_ADDR, 0, first word address tested
ERR_CNT_W, 16, error counter width (saturating)
LFSR_SEED, 32'hACE1_2024, LFSR seed, nonzero

Ports:
io_systemClk  in  1  clock
io_systemReset  in  1  synchronous active-high reset
io_start  in  1  one-cycle start pulse; ignored unless state is IDLE or DONE
io_mode  in  2  0=address-as-data, 1=LFSR, 2=walking-one, 3=inverse address; sampled at start
io_continuous  in  1  when 1, re-run forever after each pass; sampled at start
mem_cmd_valid  out  1  command valid
mem_cmd_ready  in  1  command accepted
mem_cmd_write  out  1  1=write, 0=read
mem_cmd_addr  out  ADDR_W  word address
mem_cmd_wdata  out  DATA_W  write data
mem_rsp_valid  in  1  read data valid
mem_rsp_rdata  in  DATA_W  read data
busy  out  1  test in progress
memoryCheckerPass  out  1  last completed pass had zero errors
memoryCheckerFail  out  1  at least one mismatch since start
err_count  out  ERR_CNT_W  mismatch count, saturating at all-ones
first_err_addr  out  ADDR_W  address of first mismatch
pass_count  out  16  completed full passes, wraps

Behaviour:
- Reset, synchronous on io_systemReset: state IDLE, all outputs 0, idx=0, LFSR=LFSR_SEED. Reset mid-operation abandons the test immediately. mem_cmd_valid drops the cycle after reset is sampled.
- States: IDLE -> WRITE -> READ -> WAIT_RSP -> READ ... -> CHECK_END -> (WRITE if continuous) | DONE.
- IDLE/DONE + io_start=1:
  - latch mode and continuous;
  - idx=0, LFSR=seed;
  - clear err_count, first_err_addr, Fail, Pass, pass_count;
  - go to WRITE next cycle.
- WRITE:
  - mem_cmd_valid=1, write=1, addr=BASE_ADDR+idx, wdata=pat(idx).
  - On valid&ready: idx++, LFSR advances.
  - Accepting idx=DEPTH-1 sets idx=0, reloads LFSR=seed, goes to READ.
  - Command fields are held stable while valid & !ready.
- READ:
  - mem_cmd_valid=1, write=0, addr=BASE_ADDR+idx.
  - On acceptance go to WAIT_RSP. Exactly one read is outstanding at a time.
- WAIT_RSP, on mem_rsp_valid:
  - compare rdata against pat(idx).
  - Mismatch: err_count+1, saturating; Fail=1. If this is the first error since start, first_err_addr=BASE_ADDR+idx.
  - idx++, LFSR advances. Return to READ, or go to CHECK_END after idx=DEPTH-1.
  - mem_rsp_valid in any other state is ignored.
- CHECK_END, one cycle:
  - pass_count++.
  - memoryCheckerPass = (no error in this pass). A per-pass error flag tracks this; Fail stays sticky.
  - continuous=1: idx=0, LFSR=seed, go to WRITE. Otherwise go to DONE.
- busy=1 in WRITE, READ, WAIT_RSP and CHECK_END.
- Patterns (address arithmetic is modulo 2^ADDR_W):
  - mode0: zero-extended or truncated (BASE_ADDR+idx).
  - mode1: Fibonacci LFSR x^32+x^22+x^2+x+1, shift left, feedback into bit0. Low DATA_W bits used; for DATA_W>32 the word is {lfsr,lfsr} truncated. Advances once per accepted write or received read.
  - mode2: 1<<(idx mod DATA_W).
  - mode3: ~mode0.
- io_start while busy is ignored. DEPTH=1 is legal: one write, then one read.
- pat(idx) is registered-compatible: compare and write data are combinational from idx/LFSR, and no extra pipeline latency is added.

Test Plan:
1. Zero-wait memory model, mode0, DEPTH=8, BASE_ADDR=0x10, start -> 8 writes, data 0x10..0x17; 8 reads; pass_count=1, Pass=1, Fail=0, err_count=0; DONE reached 8+16+1 cycles after start with 1-cycle read latency.
2. Model corrupts the read at addr 0x13 (bit 0 flipped), mode2 -> err_count=1, first_err_addr=0x13, Fail=1, Pass=0.
3. Random mem_cmd_ready stalls (50%) and 0-5 cycle response delay, mode1, DEPTH=64 -> Pass=1; wdata/addr stable across every stalled cycle; read data order matches LFSR sequence from seed 0xACE12024.
4. continuous=1, clean memory, 3 passes, then inject an error in pass 4 only -> pass_count increments to 5; Pass=0 after pass 4, Pass=1 after pass 5, Fail stays 1.
5. Assert io_systemReset during READ of idx 20 -> next cycle all outputs 0, state IDLE; a fresh start re-runs from idx 0.
6. ERR_CNT_W=4, all reads return 0, mode3, DEPTH=32 -> err_count saturates at 15; first_err_addr=BASE_ADDR.
